// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the shared-RAM arbiter: FSM states,
// requester identifiers and the width of the access-length counter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_IO  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface ram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [1:0]    req;
  logic [1:0]    wr;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          ram_cs;
  logic          ram_rd;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    output req, wr, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  ack, rdata, busy, ram_cs, ram_rd, ram_wr, ram_addr, ram_wdata
  );

  modport slave (
    input  req, wr, addr0, addr1, wdata0, wdata1, ram_rdata,
    output ack, rdata, busy, ram_cs, ram_rd, ram_wr, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to whichever requester was not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);
  always_comb begin
    valid  = |req;
    winner = req[1] & (~req[0] | ~last);
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shared data RAM arbiter: grants the CPU or IO engine one fixed-length RAM
// access at a time, then pulses ack to the owner for a single cycle.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_reg;
  logic              last_reg;
  logic              owner_reg;
  logic              wr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [AW-1:0]     addr_reg;
  logic [DW-1:0]     wdata_reg;
  logic [DW-1:0]     rdata_reg;
  logic [1:0]        ack_reg;

  logic              pick_valid;
  logic              pick_winner;

  rr_pick2 u_pick (
    .req    (bus.req),
    .last   (last_reg),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= OWN_IO;
      owner_reg <= OWN_CPU;
      wr_reg    <= 1'b0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ack_reg   <= '0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            owner_reg <= pick_winner;
            last_reg  <= pick_winner;
            wr_reg    <= bus.wr[pick_winner];
            addr_reg  <= pick_winner ? bus.addr1 : bus.addr0;
            wdata_reg <= pick_winner ? bus.wdata1 : bus.wdata0;
            cnt_reg   <= CNT_LOAD;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            if (!wr_reg) begin
              rdata_reg <= bus.ram_rdata;
            end
            ack_reg   <= owner_reg ? 2'b10 : 2'b01;
            // Address/data buses idle at zero outside the access window.
            addr_reg  <= '0;
            wdata_reg <= '0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset drops them without waiting for a clock edge.
  assign bus.ram_cs    = (state_reg == ACCESS);
  assign bus.ram_rd    = (state_reg == ACCESS) & ~wr_reg;
  assign bus.ram_wr    = (state_reg == ACCESS) & wr_reg;
  assign bus.ram_addr  = addr_reg;
  assign bus.ram_wdata = wdata_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.ack       = ack_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single accesses, then tie
// alternation, mid-access req drop and mid-access reset sequences.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(8), .DW(8)) bus ();

  ram_arbiter #(.AW(8), .DW(8), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Simple RAM model: asynchronous read, write on the clock while strobed.
  logic [7:0] mem [256];
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_wr) mem[bus.ram_addr] = bus.ram_wdata;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         owner;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one requester; the other port carries inverted junk so a wrong
  // mux selection shows up on ram_addr/ram_wdata.
  task automatic apply(input int owner, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.req    = (owner == 1) ? 2'b10 : 2'b01;
    bus.wr     = (owner == 1) ? {w, ~w} : {~w, w};
    bus.addr0  = (owner == 1) ? ~a : a;
    bus.addr1  = (owner == 1) ? a : ~a;
    bus.wdata0 = (owner == 1) ? ~d : d;
    bus.wdata1 = (owner == 1) ? d : ~d;
  endtask

  // Called at the negedge just before the granting edge; returns at the
  // negedge where ack is high.
  task automatic run_access(input string tag, input int owner, input logic w,
                            input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] exp_rdata, input int drop_at);
    int waited  = 0;
    int strobes = 0;
    bit got     = 0;
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      if (drop_at == waited) begin
        bus.req   = 2'b00;
        bus.addr0 = 8'h99;
        bus.addr1 = 8'h99;
        bus.wr    = ~bus.wr;
      end
      if (bus.ram_cs) begin
        strobes++;
        chk({tag, "_ram_addr"}, bus.ram_addr, a);
        chk({tag, "_ram_rd"}, bus.ram_rd, !w);
        chk({tag, "_ram_wr"}, bus.ram_wr, w);
        if (w) chk({tag, "_ram_wdata"}, bus.ram_wdata, d);
      end
      if (bus.ack != 2'b00) begin
        got = 1;
        chk({tag, "_ack"}, bus.ack, (owner == 1) ? 2'b10 : 2'b01);
        chk({tag, "_rdata"}, bus.rdata, exp_rdata);
        chk({tag, "_cs_in_done"}, bus.ram_cs, 1'b0);
        chk({tag, "_addr_idle"}, bus.ram_addr, 8'h00);
        chk({tag, "_latency"}, waited, 3);
        chk({tag, "_strobe_cycles"}, strobes, 2);
      end
    end
    chk({tag, "_ack_seen"}, got, 1'b1);
    $display("txn %s owner=%0d wr=%0b addr=%02h rdata=%02h cycles=%0d", tag, owner, w, a, bus.rdata, waited);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack_clear"}, bus.ack, 2'b00);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_cs"}, bus.ram_cs, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h3C] = 8'hA5;

    vecs[0] = '{0, 1'b0, 8'h3C, 8'h00, 8'hA5};
    vecs[1] = '{1, 1'b1, 8'h10, 8'h7E, 8'hA5};
    vecs[2] = '{1, 1'b0, 8'h10, 8'h00, 8'h7E};
    vecs[3] = '{0, 1'b1, 8'hFF, 8'h55, 8'h7E};
    vecs[4] = '{0, 1'b0, 8'hFF, 8'h00, 8'h55};
    vecs[5] = '{1, 1'b0, 8'h00, 8'h00, 8'h5A};

    rst        = 1'b1;
    bus.req    = 2'b00;
    bus.wr     = 2'b00;
    bus.addr0  = 8'h00;
    bus.addr1  = 8'h00;
    bus.wdata0 = 8'h00;
    bus.wdata1 = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("reset_ack", bus.ack, 2'b00);
      chk("reset_rdata", bus.rdata, 8'h00);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_strobes", {bus.ram_cs, bus.ram_rd, bus.ram_wr}, 3'b000);
      chk("reset_ram_addr", bus.ram_addr, 8'h00);
      chk("reset_ram_wdata", bus.ram_wdata, 8'h00);
    end

    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].owner, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      run_access($sformatf("vec%0d", i), vecs[i].owner, vecs[i].wr, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_rdata, 0);
      bus.req = 2'b00;
      @(negedge clk);
      chk_idle($sformatf("vec%0d_post", i));
    end

    // Continuous tie: CPU, IO, CPU, IO with one IDLE cycle between accesses.
    bus.req   = 2'b11;
    bus.wr    = 2'b00;
    bus.addr0 = 8'h20;
    bus.addr1 = 8'h21;
    for (int k = 0; k < 4; k++) begin
      run_access($sformatf("tie%0d", k), k % 2, 1'b0, (k % 2) ? 8'h21 : 8'h20,
                 8'h00, (k % 2) ? 8'h7B : 8'h7A, 0);
      if (k == 3) bus.req = 2'b00;
      @(negedge clk);
      chk($sformatf("tie%0d_gap_busy", k), bus.busy, 1'b0);
      chk($sformatf("tie%0d_gap_cs", k), bus.ram_cs, 1'b0);
    end

    // CPU drops req (and scrambles its inputs) one cycle into ACCESS.
    apply(0, 1'b0, 8'h3C, 8'h00);
    run_access("drop", 0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1);
    @(negedge clk);
    chk_idle("drop_post");

    // Reset mid-ACCESS of an IO read, with a CPU/IO tie pending across it.
    apply(1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("rst_pre_cs", bus.ram_cs, 1'b1);
    bus.req   = 2'b11;
    bus.wr    = 2'b00;
    bus.addr0 = 8'h01;
    bus.addr1 = 8'h02;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_strobes", {bus.ram_cs, bus.ram_rd, bus.ram_wr}, 3'b000);
    chk("rst_async_busy", bus.busy, 1'b0);
    chk("rst_async_addr", bus.ram_addr, 8'h00);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_ack", bus.ack, 2'b00);
      chk("rst_hold_rdata", bus.rdata, 8'h00);
    end
    rst = 1'b0;
    run_access("rst_tie", 0, 1'b0, 8'h01, 8'h00, 8'h5B, 0);
    bus.req = 2'b00;
    @(negedge clk);
    chk_idle("rst_tie_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer for the shared data RAM. The control unit's RAM requests (RAMcs/RAMrd/RAMwr path) and the IN/OUT port engine both reach the single RAM through this block. It grants one requester at a time with round-robin fairness and drives the RAM strobes for a fixed-length access. It returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- AW, 8: address width.
- DW, 8: data width.
- WAIT_CYCLES, 2: cycles the RAM strobes are held per access. Legal values are 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req  in  2  access request; bit 0 = control unit (CPU), bit 1 = IO engine.
- wr  in  2  per-requester direction; 1 = write, 0 = read.
- addr0, addr1  in  AW each  per-requester address.
- wdata0, wdata1  in  DW each  per-requester write data.
- ack  out  2  one-cycle completion pulse to the owning requester.
- rdata  out  DW  read data; valid while ack is high, held until the next read completes.
- busy  out  1  high while the arbiter is in any state other than IDLE.
- ram_cs, ram_rd, ram_wr  out  1 each  RAM strobes.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE:**
  - If any req bit is high, pick the owner.
  - On that edge, latch wr/addr/wdata of the owner into internal registers, load cnt = WAIT_CYCLES-1, and go to ACCESS.
  - If no req bit is high, stay in IDLE.
- **Pick rule:**
  - If only one request is high, that requester wins.
  - If both are high, the requester that is not last_owner wins.
  - last_owner updates to the winner on the grant edge.
- **ACCESS:**
  - ram_cs = 1.
  - ram_rd = ~wr_lat and ram_wr = wr_lat.
  - ram_addr and ram_wdata come from the latched values.
  - Each edge with cnt != 0: decrement cnt.
  - Edge with cnt == 0: on reads, capture ram_rdata into rdata; then go to DONE.
- **DONE:**
  - All RAM strobes are 0.
  - ack[owner] = 1 for exactly this cycle.
  - The next edge always returns to IDLE.
- **Requester handshake:**
  - Hold req, wr, addr and wdata stable from assertion until ack is sampled high.
  - Deassert req on that same edge.
  - A req still high in the IDLE following DONE is a new request.
- Requester inputs are ignored outside IDLE. Changing them mid-access has no effect on the access in flight.
- If a requester drops req mid-access, the access still completes and ack is still pulsed.
- On writes, rdata keeps its previous value.
- ram_addr, ram_wdata and rdata are registered. ram_addr and ram_wdata are 0 when not in ACCESS.

## Timing
- Reset values:
  - state = IDLE, last_owner = 1 (so CPU wins the first tie), cnt = 0.
  - ack = 0, rdata = 0, busy = 0.
  - ram_cs/ram_rd/ram_wr = 0, ram_addr = 0, ram_wdata = 0.
- Cycle sequence for a request sampled at edge E0:
  - ACCESS occupies E0..E0+WAIT_CYCLES.
  - ack is high between edges E0+WAIT_CYCLES and E0+WAIT_CYCLES+1.
  - IDLE follows for at least one cycle.
- Throughput is one access per WAIT_CYCLES+2 cycles.
- Under continuous dual requests, grants alternate CPU, IO, CPU, IO and so on.
- rst asserted mid-ACCESS: strobes drop immediately, without waiting for the clock. No ack is issued, and the access counts as lost.
- Simultaneous req rise on both ports at reset release: CPU is granted first.

## Structure
- **Package ram_arb_pkg:**
  - state enum: IDLE, ACCESS, DONE.
  - owner constants: OWN_CPU = 0, OWN_IO = 1.
  - width of cnt: 4 bits.
- **Sub-module rr_pick2:** a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: valid, winner.
  - Instantiated once and reused by any future arbiter of the same shape.
- The FSM, counter, latches and output registers stay in ram_arbiter.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, busy 0.
- CPU read addr 0x3C, RAM model returns 0xA5, WAIT_CYCLES=2 -> ram_cs/ram_rd high for 2 cycles with ram_addr = 0x3C; ack[0] pulses 1 cycle after them; rdata = 0xA5.
- IO write 0x7E to addr 0x10 -> ram_wr high 2 cycles with ram_addr = 0x10 and ram_wdata = 0x7E; ack[1] pulses once; rdata unchanged.
- Both req held high for 4 accesses -> grant order CPU, IO, CPU, IO; each access is separated by exactly one IDLE cycle.
- CPU drops req one cycle into ACCESS -> access completes and ack[0] still pulses.
- rst asserted mid-ACCESS of an IO read -> strobes 0 within the same cycle, no ack; after release, a pending CPU and IO tie grants CPU first.
